// File: rtl/fifo_pkg.sv
// Shared types and line levels for the FIFO drain-side serial transmitter.
package fifo_pkg;

    // Transmitter sequencing: fetch a word (POP/WAIT), then send start, data and stop bits.
    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        START,
        DATA,
        STOP
    } tx_state_e;

    // The serial line idles at mark level. A frame begins with a space.
    localparam logic TX_IDLE_LVL  = 1'b1;
    localparam logic TX_START_LVL = 1'b0;

endpackage

// File: rtl/baud_divider.sv
// Bit-period timer: tick is high on the last clock of every BAUD_DIV-clock bit.
// clr restarts the period so that a frame's first bit gets its full length.
module baud_divider #(
    parameter int BAUD_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count 0..BAUD_DIV-1 and roll over on each bit boundary.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Drain end of the FIFO: pops one word per frame and sends it on a UART-style line
// (start bit, WIDTH data bits LSB first, stop bit; each bit held BAUD_DIV clocks).
// fifo_pop, tx and busy are decoded from registered state only.
module fifo_serial_tx
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int BAUD_DIV   = 2,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_out,
    output logic             fifo_pop,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    // Reject parameter values the sequencing cannot honour.
    if (BAUD_DIV < 1) begin : g_bad_baud
        $error("fifo_serial_tx: BAUD_DIV must be >= 1");
    end
    if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_latency
        $error("fifo_serial_tx: RD_LATENCY must be 0 or 1");
    end

    tx_state_e        state;
    tx_state_e        state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0] bit_idx;
    logic             tick;
    logic             baud_clr;
    logic             load_word;
    logic             shift_en;
    logic             frame_done;

    // Restart the bit timer on entry into START so the start bit lasts a full period.
    assign baud_clr = (state_nxt == START) && (state != START);

    baud_divider #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr),
        .tick(tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes. A new pop needs enable and a non-empty FIFO
    // sampled together, both from IDLE and at the end of STOP (back-to-back frames).
    // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        load_word  = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_nxt = POP;
                end
            end
            POP: begin
                if (RD_LATENCY == 0) begin
                    load_word = 1'b1;
                    state_nxt = START;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                load_word = 1'b1;
                state_nxt = START;
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    frame_done = 1'b1;
                    state_nxt  = (enable && !fifo_empty) ? POP : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Word capture, LSB-first shifting, bit index and completed-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_idx   <= '0;
            frame_cnt <= '0;
        end else begin
            if (load_word) begin
                shift_reg <= fifo_out;
            end else if (shift_en) begin
                shift_reg <= shift_reg >> 1;
            end

            if (state == START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end

            if (frame_done) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Moore output decode: no combinational path from the inputs.
    always_comb begin
        fifo_pop = (state == POP);
        busy     = (state != IDLE);
        case (state)
            START:   tx = TX_START_LVL;
            DATA:    tx = shift_reg[0];
            default: tx = TX_IDLE_LVL;
        endcase
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Self-checking bench for fifo_serial_tx. Two instances share clk/rst/enable:
//   dut  : WIDTH=4, BAUD_DIV=2, RD_LATENCY=1
//   dut0 : WIDTH=4, BAUD_DIV=1, RD_LATENCY=0
// Each has a queue-based FIFO model; the serial line is decoded by a frame-level receiver.
module tb_fifo_serial_tx;

    localparam int W   = 4;
    localparam int BD  = 2;
    localparam int BD0 = 1;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty, fifo_empty0;
    logic [W-1:0]  fifo_out, fifo_out0;
    logic          fifo_pop, fifo_pop0;
    logic          tx, tx0;
    logic          busy, busy0;
    logic [CW-1:0] frame_cnt, frame_cnt0;

    always #5 clk = ~clk;

    fifo_serial_tx #(.WIDTH(W), .BAUD_DIV(BD), .RD_LATENCY(1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_out(fifo_out),
        .fifo_pop(fifo_pop), .tx(tx), .busy(busy), .frame_cnt(frame_cnt)
    );

    fifo_serial_tx #(.WIDTH(W), .BAUD_DIV(BD0), .RD_LATENCY(0), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty0), .fifo_out(fifo_out0),
        .fifo_pop(fifo_pop0), .tx(tx0), .busy(busy0), .frame_cnt(frame_cnt0)
    );

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  q[$];
    logic [W-1:0]  q0[$];
    bit            txlog[$];
    bit            txlog0[$];
    logic [W-1:0]  dec[$];
    int            ferr;
    int            pops, pops0, busy_cyc, busy_falls;
    bit            pend = 1'b0;
    bit            pend0 = 1'b0;
    logic [CW-1:0] exp_cnt, exp_cnt0;

    // Expected line level k clocks into a frame carrying word w at b clocks per bit.
    function automatic logic frame_bit(input logic [W-1:0] w, input int b, input int k);
        int slot;
        slot = k / b;
        if (slot == 0) return 1'b0;
        if (slot <= W) return w[slot-1];
        return 1'b1;
    endfunction

    // Frame-level receiver: finds start bits in a per-clock line log and recovers words.
    function automatic void decode(input bit s[$], input int b);
        int           i;
        int           flen;
        bit           ok;
        logic [W-1:0] w;
        dec.delete();
        ferr = 0;
        i    = 0;
        flen = (W + 2) * b;
        while (i + flen <= s.size()) begin
            if (s[i] == 1'b0) begin
                for (int k = 0; k < W; k++) w[k] = s[i + (k + 1) * b];
                ok = 1'b1;
                for (int k = 0; k < flen; k++) if (s[i + k] != frame_bit(w, b, k)) ok = 1'b0;
                if (ok) begin
                    dec.push_back(w);
                    i = i + flen;
                end else begin
                    ferr++;
                    i++;
                end
            end else begin
                i++;
            end
        end
    endfunction

    task automatic refresh();
        fifo_empty  = (q.size() == 0);
        fifo_empty0 = (q0.size() == 0);
        fifo_out0   = (q0.size() != 0) ? q0[0] : '0;
    endtask

    task automatic clear_logs();
        txlog.delete();
        txlog0.delete();
        pops       = 0;
        pops0      = 0;
        busy_cyc   = 0;
        busy_falls = 0;
    endtask

    // One clock: commit the pops of the ending cycle to the FIFO models, then sample
    // the new cycle and check every pop against the rules (enable and non-empty in
    // the decision cycle, not in reset, FIFO not empty now, single-cycle strobe).
    task automatic step();
        logic en_p, emp_p, emp0_p, rst_p, busy_p;
        logic [W-1:0] w;
        en_p   = enable;
        emp_p  = fifo_empty;
        emp0_p = fifo_empty0;
        rst_p  = rst;
        busy_p = busy;
        @(posedge clk);
        #1;
        if (pend) begin
            if (q.size() != 0) begin
                w        = q.pop_front();
                fifo_out = w;
            end
            pops++;
        end
        if (pend0) begin
            if (q0.size() != 0) void'(q0.pop_front());
            pops0++;
        end
        refresh();
        if (fifo_pop) begin
            checks++;
            if (!en_p || emp_p || rst_p || fifo_empty || pend) begin
                errors++;
                $display("FAIL pop_legal t=%0t got pop=1 en_prev=%b empty_prev=%b rst_prev=%b empty=%b pop_prev=%b exp no pop",
                         $time, en_p, emp_p, rst_p, fifo_empty, pend);
            end
        end
        if (fifo_pop0) begin
            checks++;
            if (!en_p || emp0_p || rst_p || fifo_empty0 || pend0) begin
                errors++;
                $display("FAIL pop0_legal t=%0t got pop=1 en_prev=%b empty_prev=%b rst_prev=%b empty=%b pop_prev=%b exp no pop",
                         $time, en_p, emp0_p, rst_p, fifo_empty0, pend0);
            end
        end
        pend  = fifo_pop;
        pend0 = fifo_pop0;
        txlog.push_back(tx);
        txlog0.push_back(tx0);
        if (busy) busy_cyc++;
        if (busy_p && !busy) busy_falls++;
    endtask

    task automatic wait_drained(input int budget, input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || q0.size() != 0 || busy || busy0 || fifo_pop || fifo_pop0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (q.size() != 0 || q0.size() != 0 || busy || busy0) begin
            errors++;
            $display("FAIL %s_timeout got still busy after %0d cycles exp drained", name, n);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b1;
        fifo_out = '0;
        q.delete();
        q0.delete();
        q.push_back(4'h5);
        q0.push_back(4'h6);
        refresh();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx cyc=%0d got=%b exp=1", i, tx); end
            checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop cyc=%0d got=%b exp=0", i, fifo_pop); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy); end
            checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt cyc=%0d got=%0d exp=0", i, frame_cnt); end
            checks++; if (tx0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_dut0 cyc=%0d got tx=%b busy=%b exp tx=1 busy=0", i, tx0, busy0); end
        end
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL release_tx got=%b exp=1", tx); end
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL release_pop got=%b exp=0", fifo_pop); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got=%b exp=0", busy); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL release_cnt got=%0d exp=0", frame_cnt); end
        step();
        checks++; if (busy !== 1'b0 || fifo_pop !== 1'b0) begin errors++; $display("FAIL disabled_idle got busy=%b pop=%b exp 0 0", busy, fifo_pop); end
        q.delete();
        q0.delete();
        refresh();
        exp_cnt  = '0;
        exp_cnt0 = '0;
    endtask

    task automatic test_single();
        bit lit[12] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1};
        clear_logs();
        q.push_back(4'hA);
        refresh();
        enable = 1'b1;
        step();
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL single_pop got=%b exp=1", fifo_pop); end
        step();
        checks++; if (fifo_pop !== 1'b0 || busy !== 1'b1 || tx !== 1'b1) begin
            errors++; $display("FAIL single_wait got pop=%b busy=%b tx=%b exp 0 1 1", fifo_pop, busy, tx);
        end
        for (int k = 0; k < (W + 2) * BD; k++) begin
            step();
            checks++; if (tx !== frame_bit(4'hA, BD, k)) begin errors++; $display("FAIL single_tx k=%0d got=%b exp=%b", k, tx, frame_bit(4'hA, BD, k)); end
            checks++; if (tx !== lit[k]) begin errors++; $display("FAIL single_tx_literal k=%0d got=%b exp=%b", k, tx, lit[k]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy k=%0d got=%b exp=1", k, busy); end
        end
        step();
        exp_cnt = exp_cnt + 8'd1;
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL single_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_end got busy=%b tx=%b exp 0 1", busy, tx); end
        checks++; if (pops != 1) begin errors++; $display("FAIL single_pops got=%0d exp=1", pops); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        for (int i = 0; i < 5; i++) q.push_back(W'(i));
        refresh();
        enable = 1'b1;
        wait_drained(300, "b2b");
        decode(txlog, BD);
        checks++; if (pops != 5) begin errors++; $display("FAIL b2b_pops got=%0d exp=5", pops); end
        checks++; if (dec.size() != 5 || ferr != 0) begin errors++; $display("FAIL b2b_frames got=%0d bad=%0d exp 5 0", dec.size(), ferr); end
        for (int i = 0; i < 5 && i < dec.size(); i++) begin
            checks++; if (dec[i] !== W'(i)) begin errors++; $display("FAIL b2b_word i=%0d got=%h exp=%h", i, dec[i], W'(i)); end
        end
        checks++; if (busy_cyc != 5 * (2 + (W + 2) * BD)) begin
            errors++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", busy_cyc, 5 * (2 + (W + 2) * BD));
        end
        checks++; if (busy_falls != 1) begin errors++; $display("FAIL b2b_idle_gaps got=%0d exp=1", busy_falls); end
        exp_cnt = exp_cnt + 8'd5;
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_enable_drop();
        clear_logs();
        q.push_back(4'h5);
        q.push_back(4'h6);
        q.push_back(4'h7);
        refresh();
        enable = 1'b1;
        step();
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL drop_first_pop got=%b exp=1", fifo_pop); end
        repeat (4) step();
        enable = 1'b0;
        repeat (60) step();
        checks++; if (pops != 1) begin errors++; $display("FAIL drop_no_pop got pops=%0d exp=1", pops); end
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL drop_idle got busy=%b tx=%b exp 0 1", busy, tx); end
        checks++; if (frame_cnt !== exp_cnt + 8'd1) begin errors++; $display("FAIL drop_cnt got=%0d exp=%0d", frame_cnt, exp_cnt + 8'd1); end
        enable = 1'b1;
        step();
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL drop_resume_pop got=%b exp=1", fifo_pop); end
        wait_drained(200, "drop");
        decode(txlog, BD);
        checks++; if (dec.size() != 3 || ferr != 0) begin errors++; $display("FAIL drop_frames got=%0d bad=%0d exp 3 0", dec.size(), ferr); end
        for (int i = 0; i < 3 && i < dec.size(); i++) begin
            checks++; if (dec[i] !== W'(i + 5)) begin errors++; $display("FAIL drop_word i=%0d got=%h exp=%h", i, dec[i], W'(i + 5)); end
        end
        exp_cnt = exp_cnt + 8'd3;
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL drop_end_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_random();
        logic [W-1:0] ref_q[$];
        logic [W-1:0] ref_q0[$];
        logic [W-1:0] w;
        int n, n0;
        clear_logs();
        n  = $urandom_range(3, 6);
        n0 = $urandom_range(3, 8);
        for (int i = 0; i < n; i++) begin w = W'($urandom); q.push_back(w); ref_q.push_back(w); end
        for (int i = 0; i < n0; i++) begin w = W'($urandom); q0.push_back(w); ref_q0.push_back(w); end
        refresh();
        for (int c = 0; c < 150; c++) begin
            enable = ($urandom_range(0, 3) != 0);
            step();
        end
        enable = 1'b1;
        wait_drained(500, "random");
        decode(txlog, BD);
        checks++; if (dec.size() != n || ferr != 0 || pops != n) begin
            errors++; $display("FAIL rand_frames got=%0d bad=%0d pops=%0d exp %0d 0 %0d", dec.size(), ferr, pops, n, n);
        end
        for (int i = 0; i < n && i < dec.size(); i++) begin
            checks++; if (dec[i] !== ref_q[i]) begin errors++; $display("FAIL rand_word i=%0d got=%h exp=%h", i, dec[i], ref_q[i]); end
        end
        decode(txlog0, BD0);
        checks++; if (dec.size() != n0 || ferr != 0 || pops0 != n0) begin
            errors++; $display("FAIL rand0_frames got=%0d bad=%0d pops=%0d exp %0d 0 %0d", dec.size(), ferr, pops0, n0, n0);
        end
        for (int i = 0; i < n0 && i < dec.size(); i++) begin
            checks++; if (dec[i] !== ref_q0[i]) begin errors++; $display("FAIL rand0_word i=%0d got=%h exp=%h", i, dec[i], ref_q0[i]); end
        end
        exp_cnt  = exp_cnt + CW'(n);
        exp_cnt0 = exp_cnt0 + CW'(n0);
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL rand_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
        checks++; if (frame_cnt0 !== exp_cnt0) begin errors++; $display("FAIL rand0_cnt got=%0d exp=%0d", frame_cnt0, exp_cnt0); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        q.push_back(4'h9);
        q.push_back(4'hC);
        refresh();
        enable = 1'b1;
        step();
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL rstmid_pop got=%b exp=1", fifo_pop); end
        repeat (8) step();
        checks++; if (tx !== frame_bit(4'h9, BD, 3 * BD)) begin errors++; $display("FAIL rstmid_bit2 got=%b exp=%b", tx, frame_bit(4'h9, BD, 3 * BD)); end
        rst = 1'b1;
        step();
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs got tx=%b busy=%b pop=%b exp 1 0 0", tx, busy, fifo_pop);
        end
        checks++; if (frame_cnt !== 8'd0 || frame_cnt0 !== 8'd0) begin
            errors++; $display("FAIL rstmid_cnt got=%0d/%0d exp 0/0", frame_cnt, frame_cnt0);
        end
        exp_cnt  = '0;
        exp_cnt0 = '0;
        rst = 1'b0;
        clear_logs();
        wait_drained(200, "rstmid");
        decode(txlog, BD);
        checks++; if (dec.size() != 1 || ferr != 0) begin errors++; $display("FAIL rstmid_frames got=%0d bad=%0d exp 1 0", dec.size(), ferr); end
        if (dec.size() != 0) begin
            checks++; if (dec[0] !== 4'hC) begin errors++; $display("FAIL rstmid_word got=%h exp=c", dec[0]); end
        end
        exp_cnt = exp_cnt + 8'd1;
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL rstmid_end_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_empty_boundary();
        clear_logs();
        q.push_back(4'h3);
        q.push_back(4'h4);
        refresh();
        enable = 1'b1;
        step();
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL empty_pop got=%b exp=1", fifo_pop); end
        repeat (13) step();
        checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL empty_last_stop got tx=%b busy=%b exp 1 1", tx, busy); end
        q.delete();
        refresh();
        step();
        checks++; if (busy !== 1'b0 || tx !== 1'b1 || fifo_pop !== 1'b0) begin
            errors++; $display("FAIL empty_to_idle got busy=%b tx=%b pop=%b exp 0 1 0", busy, tx, fifo_pop);
        end
        repeat (5) step();
        checks++; if (pops != 1 || busy !== 1'b0) begin errors++; $display("FAIL empty_no_pop got pops=%0d busy=%b exp 1 0", pops, busy); end
        exp_cnt = exp_cnt + 8'd1;
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL empty_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_rdlat0();
        logic [W-1:0] w;
        clear_logs();
        w = W'($urandom);
        q0.push_back(w);
        refresh();
        enable = 1'b1;
        step();
        checks++; if (fifo_pop0 !== 1'b1) begin errors++; $display("FAIL lat0_pop got=%b exp=1", fifo_pop0); end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (tx0 !== frame_bit(w, BD0, k)) begin errors++; $display("FAIL lat0_tx k=%0d got=%b exp=%b", k, tx0, frame_bit(w, BD0, k)); end
        end
        step();
        exp_cnt0 = exp_cnt0 + 8'd1;
        checks++; if (busy0 !== 1'b0 || tx0 !== 1'b1) begin errors++; $display("FAIL lat0_end got busy=%b tx=%b exp 0 1", busy0, tx0); end
        checks++; if (frame_cnt0 !== exp_cnt0 || pops0 != 1) begin
            errors++; $display("FAIL lat0_cnt got cnt=%0d pops=%0d exp %0d 1", frame_cnt0, pops0, exp_cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_random();
        test_reset_mid();
        test_empty_boundary();
        test_rdlat0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no completion exp finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
